queue_arbiter: RTL and testbench

QUEUE_ARBITER -- requirements
Module: queue_arbiter

---
 rtl/queue_arbiter_if.sv | 35 +++
 rtl/queue_arbiter.sv | 90 +++++++++
 tb/tb_queue_arbiter.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/queue_arbiter_if.sv
// Bundles the producer and consumer signals of queue_arbiter.
//   req           : per-producer enqueue request (NREQ)
//   req_data      : producer data, slice i = [i*DW +: DW]
//   grant         : one-hot acceptance strobe (combinational)
//   deq           : consumer pop request
//   data_out      : head-of-queue data (show-ahead), zero when empty
//   full / empty  : occupancy flags
//   count         : occupancy 0..DEPTH
//   underflow_err : sticky, set by deq while empty
// The slave modport is the queue side, master is the producer/consumer side.
interface queue_arbiter_if #(
   parameter int NREQ  = 4,
   parameter int DW    = 8,
   parameter int DEPTH = 8
);
   logic [NREQ-1:0]          req;
   logic [NREQ*DW-1:0]       req_data;
   logic [NREQ-1:0]          grant;
   logic                     deq;
   logic [DW-1:0]            data_out;
   logic                     full;
   logic                     empty;
   logic [$clog2(DEPTH):0]   count;
   logic                     underflow_err;

   modport slave (
      input  req, req_data, deq,
      output grant, data_out, full, empty, count, underflow_err
   );

   modport master (
      output req, req_data, deq,
      input  grant, data_out, full, empty, count, underflow_err
   );
endinterface

// File: rtl/queue_arbiter.sv
// Round-robin arbitrated FIFO: NREQ producers compete for one enqueue slot
// per cycle into a DEPTH x DW queue drained by a single consumer.
//   clk : rising-edge clock
//   rst : asynchronous active-low reset
//   bus : queue_arbiter_if.slave (req/req_data/grant, deq/data_out, flags)
module queue_arbiter #(
   parameter int NREQ  = 4,
   parameter int DW    = 8,
   parameter int DEPTH = 8
) (
   input logic            clk,
   input logic            rst,
   queue_arbiter_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int IW = $clog2(NREQ);

   logic [DW-1:0]             mem [DEPTH];
   logic [AW-1:0]             head, tail;
   logic [CW-1:0]             cnt;
   logic [IW-1:0]             last;
   logic                      uflow;

   logic [NREQ-1:0][DW-1:0]   slices;
   logic                      empty, full, pop, space, found, enq;
   logic [IW-1:0]             win, cand;

   assign slices = bus.req_data;

   // Occupancy comes only from the counter; head == tail is ambiguous.
   assign empty = (cnt == '0);
   assign full  = (cnt == CW'(DEPTH));
   assign pop   = bus.deq && !empty;
   // A pop in the same cycle frees the slot the enqueue needs.
   assign space = !full || pop;

   // Round-robin search starting just after the previous winner.
   always_comb begin
      found = 1'b0;
      win   = last;
      cand  = '0;
      for (int k = 1; k <= NREQ; k++) begin
         cand = IW'((int'(last) + k) % NREQ);
         if (!found && bus.req[cand]) begin
            found = 1'b1;
            win   = cand;
         end
      end
   end

   // Gate with rst so nothing is granted while reset is held.
   assign enq = found && space && rst;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head  <= '0;
         tail  <= '0;
         cnt   <= '0;
         last  <= IW'(NREQ - 1);
         uflow <= 1'b0;
      end else begin
         if (enq) begin
            tail <= tail + AW'(1);
            last <= win;
         end
         if (pop)
            head <= head + AW'(1);
         if (enq && !pop)
            cnt <= cnt + CW'(1);
         else if (pop && !enq)
            cnt <= cnt - CW'(1);
         if (bus.deq && empty)
            uflow <= 1'b1;
      end
   end

   // Storage is not reset; stale entries are unreachable once cnt is 0.
   always_ff @(posedge clk) begin
      if (enq)
         mem[tail] <= slices[win];
   end

   assign bus.grant         = enq ? (NREQ'(1) << win) : '0;
   assign bus.data_out      = empty ? '0 : mem[head];
   assign bus.full          = full;
   assign bus.empty         = empty;
   assign bus.count         = cnt;
   assign bus.underflow_err = uflow;
endmodule

// File: tb/tb_queue_arbiter.sv
module tb_queue_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   queue_arbiter_if #(.NREQ(4), .DW(8), .DEPTH(8)) bus();
   queue_arbiter #(.NREQ(4), .DW(8), .DEPTH(8)) dut (.clk(clk), .rst(rst), .bus(bus));

   int total = 0;
   int pass  = 0;

   // Reference model: a plain queue plus the round-robin pointer.
   logic [7:0] q[$];
   int         m_last  = 3;
   logic       m_uflow = 1'b0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
   endtask

   task automatic m_reset();
      q.delete();
      m_last  = 3;
      m_uflow = 1'b0;
   endtask

   function automatic logic [3:0] m_grant(input logic [3:0] r, input logic dq);
      bit sp;
      int idx;
      sp = (q.size() < 8) || (dq && q.size() > 0);
      if (!sp) return 4'b0;
      for (int k = 1; k <= 4; k++) begin
         idx = (m_last + k) % 4;
         if (r[idx]) return 4'(1 << idx);
      end
      return 4'b0;
   endfunction

   // One cycle: drive after the falling edge, compare against the model,
   // advance the model at the rising edge, return at the next falling edge.
   task automatic step(input logic [3:0] r, input logic [31:0] d, input logic dq);
      logic [3:0] eg;
      bit         was_empty;
      int         gi;
      bus.req = r; bus.req_data = d; bus.deq = dq;
      #1;
      eg        = m_grant(r, dq);
      was_empty = (q.size() == 0);
      check("m_grant", bus.grant, eg);
      check("m_data_out", bus.data_out, was_empty ? 8'h00 : q[0]);
      check("m_count", bus.count, q.size());
      check("m_full", bus.full, q.size() == 8);
      check("m_empty", bus.empty, was_empty);
      check("m_underflow", bus.underflow_err, m_uflow);
      @(posedge clk);
      if (dq && !was_empty) void'(q.pop_front());
      if (eg != 0) begin
         gi = 0;
         for (int i = 0; i < 4; i++) if (eg[i]) gi = i;
         q.push_back(d[gi*8 +: 8]);
         m_last = gi;
      end
      if (dq && was_empty) m_uflow = 1'b1;
      @(negedge clk);
   endtask

   typedef struct {
      logic [3:0]  req;
      logic [31:0] data;
      logic        deq;
      logic [3:0]  exp_grant;
      logic [3:0]  exp_count;
      logic [7:0]  exp_dout;
   } vec_t;

   vec_t vt[10];

   initial begin
      // Reset release, then four-way contention and 0/2 alternation.
      vt[0] = '{4'b1111, 32'h13121110, 1'b0, 4'b0001, 4'd0, 8'h00};
      vt[1] = '{4'b1111, 32'h13121110, 1'b0, 4'b0010, 4'd1, 8'h10};
      vt[2] = '{4'b1111, 32'h13121110, 1'b0, 4'b0100, 4'd2, 8'h10};
      vt[3] = '{4'b1111, 32'h13121110, 1'b0, 4'b1000, 4'd3, 8'h10};
      vt[4] = '{4'b0101, 32'hD3C2B1A0, 1'b1, 4'b0001, 4'd4, 8'h10};
      vt[5] = '{4'b0101, 32'hD3C2B1A0, 1'b1, 4'b0100, 4'd4, 8'h11};
      vt[6] = '{4'b0101, 32'hD3C2B1A0, 1'b1, 4'b0001, 4'd4, 8'h12};
      vt[7] = '{4'b0101, 32'hD3C2B1A0, 1'b1, 4'b0100, 4'd4, 8'h13};
      vt[8] = '{4'b0101, 32'hD3C2B1A0, 1'b1, 4'b0001, 4'd4, 8'hA0};
      vt[9] = '{4'b0101, 32'hD3C2B1A0, 1'b1, 4'b0100, 4'd4, 8'hC2};

      bus.req = '0; bus.req_data = '0; bus.deq = 1'b0;
      rst = 1'b0;
      bus.req = 4'b1111;
      #1;
      check("reset_grant", bus.grant, 4'b0);
      check("reset_empty", bus.empty, 1'b1);
      check("reset_full", bus.full, 1'b0);
      check("reset_count", bus.count, 4'd0);
      check("reset_data_out", bus.data_out, 8'h00);
      bus.req = '0;
      @(negedge clk); @(negedge clk);
      rst = 1'b1;
      m_reset();

      foreach (vt[i]) begin
         bus.req = vt[i].req; bus.req_data = vt[i].data; bus.deq = vt[i].deq;
         #1;
         check($sformatf("vec%0d_grant", i), bus.grant, vt[i].exp_grant);
         check($sformatf("vec%0d_count", i), bus.count, vt[i].exp_count);
         check($sformatf("vec%0d_data_out", i), bus.data_out, vt[i].exp_dout);
         step(vt[i].req, vt[i].data, vt[i].deq);
      end
      check("vec_end_count", bus.count, 4'd4);

      // Drain, then fill through the pointer wrap from producer 2 only.
      for (int i = 0; i < 4; i++) step(4'b0000, 32'h0, 1'b1);
      for (int v = 1; v <= 8; v++) begin
         bus.req = 4'b0100; bus.req_data = 32'(v) << 16; bus.deq = 1'b0;
         #1;
         check("fill_grant", bus.grant, 4'b0100);
         step(4'b0100, 32'(v) << 16, 1'b0);
      end
      for (int i = 0; i < 2; i++) begin
         bus.req = 4'b0100; bus.req_data = 32'h00090000; bus.deq = 1'b0;
         #1;
         check("full_flag", bus.full, 1'b1);
         check("full_grant", bus.grant, 4'b0000);
         check("full_count", bus.count, 4'd8);
         step(4'b0100, 32'h00090000, 1'b0);
      end

      // Full with simultaneous enqueue and pop.
      bus.req = 4'b0001; bus.req_data = 32'h000000EE; bus.deq = 1'b1;
      #1;
      check("fullpop_grant", bus.grant, 4'b0001);
      step(4'b0001, 32'h000000EE, 1'b1);
      check("fullpop_count", bus.count, 4'd8);

      for (int i = 0; i < 8; i++) begin
         bus.req = '0; bus.deq = 1'b1;
         #1;
         check("drain_data_out", bus.data_out, (i < 7) ? 8'(i + 2) : 8'hEE);
         step(4'b0000, 32'h0, 1'b1);
      end
      check("drain_empty", bus.empty, 1'b1);

      // Underflow is sticky until reset.
      step(4'b0000, 32'h0, 1'b1);
      check("uflow_set", bus.underflow_err, 1'b1);
      check("uflow_count", bus.count, 4'd0);
      step(4'b0000, 32'h0, 1'b0);
      step(4'b0000, 32'h0, 1'b0);
      check("uflow_sticky", bus.underflow_err, 1'b1);
      rst = 1'b0;
      #1;
      check("uflow_cleared", bus.underflow_err, 1'b0);
      m_reset();
      @(negedge clk);
      rst = 1'b1;

      // Mid-cycle asynchronous reset with five entries queued.
      for (int i = 0; i < 5; i++) step(4'b0001, 32'(8'h30 + i), 1'b0);
      check("pre_rst_count", bus.count, 4'd5);
      bus.req = 4'b0001;
      #2;
      rst = 1'b0;
      #1;
      check("async_count", bus.count, 4'd0);
      check("async_empty", bus.empty, 1'b1);
      check("async_grant", bus.grant, 4'b0000);
      check("async_data_out", bus.data_out, 8'h00);
      m_reset();
      @(negedge clk);
      rst = 1'b1;
      step(4'b0001, 32'h0000005A, 1'b0);
      check("post_rst_entry0", dut.mem[0], 8'h5A);
      check("post_rst_data_out", bus.data_out, 8'h5A);
      check("post_rst_count", bus.count, 4'd1);

      // Random traffic against the model.
      for (int i = 0; i < 600; i++)
         step(4'($urandom_range(0, 15)), $urandom, ($urandom_range(0, 99) < 45));

      $display("%0d/%0d checks passed", pass, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench did not complete");
      $fatal(1);
   end
endmodule
